// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared constants for the ALU control sequencer and its funct decoder:
//   - ALU operation encodings, which match the 1-bit ALU slice chain
//   - MIPS R-type funct codes handled by the controller
//   - result-mux select codes
//   - FSM state type and state constants
package alu_ctrl_pkg;

    // ALU operation encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // R-type funct codes
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Result mux selects
    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_SHF = 2'b01;
    localparam logic [1:0] SEL_HI  = 2'b10;
    localparam logic [1:0] SEL_LO  = 2'b11;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_MUL_LOAD = 2'd1;
    localparam state_t ST_MUL_RUN  = 2'd2;
    localparam state_t ST_MUL_DONE = 2'd3;

endpackage

// File: rtl/alu_funct_dec.sv
// alu_funct_dec
// Purely combinational funct decoder for the ALU controller.
// Ports:
//   funct      in   6  R-type funct field
//   cur_alu    in   3  currently driven ALU operation
//   alu_signal out  3  ALU operation to use if this funct is accepted
//   sel_out    out  2  result-mux select to use if this funct is accepted
//   is_mul     out  1  funct is MULTU (multi-cycle sequence)
//   is_illegal out  1  funct is not supported
module alu_funct_dec
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [2:0] cur_alu,
    output logic [2:0] alu_signal,
    output logic [1:0] sel_out,
    output logic       is_mul,
    output logic       is_illegal
);

    // Shift and HI/LO moves do not use the ALU, so the current ALU
    // operation is passed through and the controller's value is kept.
    always_comb begin
        alu_signal = cur_alu;
        sel_out    = SEL_ALU;
        is_mul     = 1'b0;
        is_illegal = 1'b0;
        case (funct)
            FN_ADD:   alu_signal = ALU_ADD;
            FN_SUB:   alu_signal = ALU_SUB;
            FN_AND:   alu_signal = ALU_AND;
            FN_OR:    alu_signal = ALU_OR;
            FN_SLT:   alu_signal = ALU_SLT;
            FN_SRL:   sel_out    = SEL_SHF;
            FN_MFHI:  sel_out    = SEL_HI;
            FN_MFLO:  sel_out    = SEL_LO;
            FN_MULTU: is_mul     = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
// ALU control sequencer: turns an R-type funct into ALU operation, result
// select and write strobes, and steps the datapath multiplier through a
// WIDTH-cycle MULTU.
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   valid      in   1  funct presented this cycle
//   funct      in   6  R-type funct field
//   ready      out  1  high only in IDLE (combinational)
//   alu_signal out  3  ALU operation (registered, held between accepts)
//   sel_out    out  2  result-mux select (registered, held between accepts)
//   reg_we     out  1  register-file write strobe
//   mul_load   out  1  product-register load strobe
//   mul_step   out  1  product-register add/shift step strobe
//   hilo_we    out  1  HI/LO write strobe
//   done       out  1  completion pulse for every accepted funct
//   illegal    out  1  unsupported-funct pulse, coincident with done
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [5:0] funct,
    output logic       ready,
    output logic [2:0] alu_signal,
    output logic [1:0] sel_out,
    output logic       reg_we,
    output logic       mul_load,
    output logic       mul_step,
    output logic       hilo_we,
    output logic       done,
    output logic       illegal
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] step_cnt;

    logic [2:0] dec_alu;
    logic [1:0] dec_sel;
    logic       dec_mul;
    logic       dec_illegal;

    alu_funct_dec u_dec (
        .funct      (funct),
        .cur_alu    (alu_signal),
        .alu_signal (dec_alu),
        .sel_out    (dec_sel),
        .is_mul     (dec_mul),
        .is_illegal (dec_illegal)
    );

    assign ready = (state == ST_IDLE);

    // Sequencer and registered outputs. Every strobe defaults low each
    // cycle so it can only be high in the one cycle that sets it.
    // The step strobe for a cycle is issued on the preceding edge, so the
    // run state spans exactly the WIDTH step cycles with step_cnt equal to
    // the index of the step being performed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            step_cnt   <= '0;
            alu_signal <= ALU_ADD;
            sel_out    <= SEL_ALU;
            reg_we     <= 1'b0;
            mul_load   <= 1'b0;
            mul_step   <= 1'b0;
            hilo_we    <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            reg_we   <= 1'b0;
            mul_load <= 1'b0;
            mul_step <= 1'b0;
            hilo_we  <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        if (dec_illegal) begin
                            done    <= 1'b1;
                            illegal <= 1'b1;
                        end else if (dec_mul) begin
                            state    <= ST_MUL_LOAD;
                            mul_load <= 1'b1;
                        end else begin
                            alu_signal <= dec_alu;
                            sel_out    <= dec_sel;
                            reg_we     <= 1'b1;
                            done       <= 1'b1;
                        end
                    end
                end
                ST_MUL_LOAD: begin
                    state      <= ST_MUL_RUN;
                    step_cnt   <= '0;
                    mul_step   <= 1'b1;
                    alu_signal <= ALU_ADD;
                end
                ST_MUL_RUN: begin
                    if (step_cnt == LAST_STEP) begin
                        state   <= ST_MUL_DONE;
                        hilo_we <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt + CNT_W'(1);
                        mul_step <= 1'b1;
                    end
                end
                ST_MUL_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq
// Directed bench for alu_ctrl_seq. Each accepted funct pushes its expected
// completion response {alu_signal, sel_out, reg_we, hilo_we, illegal} into
// a queue; a monitor pops and compares whenever done is seen.
module tb_alu_ctrl_seq;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [5:0] funct;
    logic       ready;
    logic [2:0] alu_signal;
    logic [1:0] sel_out;
    logic       reg_we;
    logic       mul_load;
    logic       mul_step;
    logic       hilo_we;
    logic       done;
    logic       illegal;

    int checks = 0;
    int fails  = 0;
    logic [7:0] expq[$];

    alu_ctrl_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .funct      (funct),
        .ready      (ready),
        .alu_signal (alu_signal),
        .sel_out    (sel_out),
        .reg_we     (reg_we),
        .mul_load   (mul_load),
        .mul_step   (mul_step),
        .hilo_we    (hilo_we),
        .done       (done),
        .illegal    (illegal)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one funct for one edge; inputs change #1 after a rising edge.
    task automatic applyStimulus(input logic [5:0] f, input logic [7:0] exp, input bit expect_resp);
        valid = 1'b1;
        funct = f;
        if (expect_resp) expq.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples on the falling edge, away from updates.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no response pending");
                end else begin
                    exp = expq.pop_front();
                    checkOutput("done_resp", {alu_signal, sel_out, reg_we, hilo_we, illegal}, exp);
                end
            end else if (rst === 1'b0) begin
                checkOutput("no_stray_strobe", {reg_we, hilo_we, illegal}, 3'b000);
            end
        end
    end

    // Main stimulus sequence
    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        funct = 6'h00;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_alu_sel", {alu_signal, sel_out}, {3'b010, 2'b00});
        checkOutput("reset_ready", ready, 1'b1);
        checkOutput("reset_strobes", {reg_we, mul_load, mul_step, hilo_we, done, illegal}, 6'b0);
        rst = 1'b0;

        // Back-to-back single-cycle ALU ops
        applyStimulus(6'h22, {3'b110, 2'b00, 3'b100}, 1'b1);
        applyStimulus(6'h24, {3'b000, 2'b00, 3'b100}, 1'b1);
        applyStimulus(6'h2A, {3'b111, 2'b00, 3'b100}, 1'b1);
        applyStimulus(6'h25, {3'b001, 2'b00, 3'b100}, 1'b1);
        applyStimulus(6'h20, {3'b010, 2'b00, 3'b100}, 1'b1);
        idleCycles(2);

        // SUB, then moves and shift keep alu_signal at 110
        applyStimulus(6'h22, {3'b110, 2'b00, 3'b100}, 1'b1);
        applyStimulus(6'h10, {3'b110, 2'b10, 3'b100}, 1'b1);
        applyStimulus(6'h12, {3'b110, 2'b11, 3'b100}, 1'b1);
        applyStimulus(6'h02, {3'b110, 2'b01, 3'b100}, 1'b1);
        // Illegal functs leave alu_signal/sel_out untouched
        applyStimulus(6'h3F, {3'b110, 2'b01, 3'b001}, 1'b1);
        applyStimulus(6'h00, {3'b110, 2'b01, 3'b001}, 1'b1);
        idleCycles(2);
        checkOutput("hold_after_illegal", {alu_signal, sel_out}, {3'b110, 2'b01});

        // MULTU accepted at edge 0; now in cycle 1
        applyStimulus(6'h19, {3'b010, 2'b01, 3'b010}, 1'b1);
        for (int i = 1; i <= 34; i++) begin
            checkOutput($sformatf("multu_cyc%0d_rdy_ld_st", i), {ready, mul_load, mul_step},
                        {1'b0, (i == 1), (i >= 2 && i <= 33)});
            if (i >= 2 && i <= 33) checkOutput($sformatf("multu_cyc%0d_alu", i), alu_signal, 3'b010);
            valid = ((i % 4) == 0) && (i < 34);
            funct = 6'h20;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        checkOutput("multu_ready_back", {ready, mul_load, mul_step, hilo_we, done}, 5'b10000);
        idleCycles(2);

        // Illegal after MULTU shows alu_signal left at ADD
        applyStimulus(6'h3F, {3'b010, 2'b01, 3'b001}, 1'b1);
        idleCycles(2);

        // Reset at cycle 10 of a MULTU; no response expected for it
        applyStimulus(6'h19, 8'h00, 1'b0);
        idleCycles(9);
        checkOutput("abort_running", {ready, mul_step}, 2'b01);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_ready", ready, 1'b1);
        checkOutput("abort_alu_sel", {alu_signal, sel_out}, {3'b010, 2'b00});
        checkOutput("abort_strobes", {reg_we, mul_load, mul_step, hilo_we, done, illegal}, 6'b0);
        idleCycles(40);
        checkOutput("abort_still_ready", ready, 1'b1);
        applyStimulus(6'h20, {3'b010, 2'b00, 3'b100}, 1'b1);
        idleCycles(3);

        // Bounded drain of outstanding responses
        for (int i = 0; i < 50 && expq.size() > 0; i++) @(posedge clk);
        #1;
        checkOutput("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
